fraction_reducer: RTL and testbench

Downstream consumer of the Greatest_Common_Divisor block. It captures the same operand pair presented to the GCD unit on `start`, waits for the GCD result, then divides both operands by it with one shared 16-bit sequential divider. The output is the reduced fraction `num/den`. It sits between the GCD core and whatever display or readout logic follows.

---
 rtl/fraction_reducer_pkg.sv | 15 +
 rtl/fraction_reducer_seq_divider.sv | 53 +++++
 rtl/fraction_reducer.sv | 96 +++++++++
 tb/tb_fraction_reducer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fraction_reducer_pkg.sv
// Shared types and constants for the fraction reducer and its divider.
package fraction_reducer_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DIV_ITERS = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GCD = 3'd1,
    DIV_A    = 3'd2,
    DIV_B    = 3'd3,
    FIN      = 3'd4
  } state_t;

endpackage

// File: rtl/fraction_reducer_seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle, MSB first.
module seq_divider
  import fraction_reducer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             last
);

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [4:0]       cnt_q;
  logic             active_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // quotient is the post-iteration value so the caller can capture it on the final edge
  always_comb begin
    shifted  = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_q};
    quotient = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    last     = active_q && (cnt_q == 5'(DIV_ITERS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dsr_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= diff[WIDTH] ? shifted : diff;
      quo_q <= quotient;
      cnt_q <= cnt_q + 5'd1;
      if (last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fraction_reducer.sv
// Reduces a/b by their GCD using a single shared sequential divider.
module fraction_reducer
  import fraction_reducer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] num,
  output logic [WIDTH-1:0] den,
  output logic             err
);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, g_q;
  logic             div_load;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quotient;
  logic             div_last;
  logic             gcd_ok;

  // first division takes the divisor straight off the gcd bus, before g_q is written
  always_comb begin
    gcd_ok       = (state_q == WAIT_GCD) && gcd_done && (gcd != '0);
    div_load     = gcd_ok || ((state_q == DIV_A) && div_last);
    div_dividend = (state_q == WAIT_GCD) ? a_q : b_q;
    div_divisor  = (state_q == WAIT_GCD) ? gcd : g_q;
    busy         = (state_q != IDLE);
    done         = (state_q == FIN);
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .last     (div_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      num     <= '0;
      den     <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            err     <= 1'b0;
            state_q <= WAIT_GCD;
          end
        end
        WAIT_GCD: begin
          if (gcd_ok) begin
            g_q     <= gcd;
            state_q <= DIV_A;
          end else if (gcd_done) begin
            num     <= '0;
            den     <= '0;
            err     <= 1'b1;
            state_q <= FIN;
          end
        end
        DIV_A: begin
          if (div_last) begin
            num     <= div_quotient;
            state_q <= DIV_B;
          end
        end
        DIV_B: begin
          if (div_last) begin
            den     <= div_quotient;
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fraction_reducer.sv
// Scoreboard bench for fraction_reducer with a behavioural GCD source.
module tb_fraction_reducer;

  typedef struct packed {
    logic [15:0] num;
    logic [15:0] den;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0, gcd = '0;
  logic        gcd_done = 1'b0;
  logic        busy, done, err;
  logic [15:0] num, den;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  exp_t sb[$];

  fraction_reducer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .gcd_done(gcd_done), .gcd(gcd), .busy(busy), .done(done),
    .num(num), .den(den), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gcd_model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic run_case(input logic [15:0] ta, input logic [15:0] tb_v);
    logic [15:0] g;
    exp_t e, got;
    int lat;
    g = gcd_model(ta, tb_v);
    if (g == 0) e = '{num: 16'd0, den: 16'd0, err: 1'b1, lat: 0};
    else        e = '{num: ta / g, den: tb_v / g, err: 1'b0, lat: 32};
    sb.push_back(e);
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_rise a=%0d b=%0d got=%b want=1", ta, tb_v, busy);
    end
    repeat (3) tick();
    gcd = g; gcd_done = 1'b1;
    tick();
    gcd_done = 1'b0; gcd = '0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout a=%0d b=%0d got=no_done want=done", ta, tb_v);
      void'(sb.pop_front());
      return;
    end
    got = '{num: num, den: den, err: err, lat: lat};
    e = sb.pop_front();
    n_cmp += 3;
    if (got.num !== e.num) begin
      n_bad++;
      $display("FAIL num a=%0d b=%0d got=%0d want=%0d", ta, tb_v, got.num, e.num);
    end
    if (got.den !== e.den) begin
      n_bad++;
      $display("FAIL den a=%0d b=%0d got=%0d want=%0d", ta, tb_v, got.den, e.den);
    end
    if (got.err !== e.err) begin
      n_bad++;
      $display("FAIL err a=%0d b=%0d got=%b want=%b", ta, tb_v, got.err, e.err);
    end
    if (got.lat != e.lat) begin
      n_bad++;
      $display("FAIL latency a=%0d b=%0d got=%0d want=%0d", ta, tb_v, got.lat, e.lat);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse a=%0d b=%0d got done=%b busy=%b want 0 0", ta, tb_v, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({busy, done, err, num, den} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset got busy=%b done=%b err=%b num=%0d den=%0d want all 0",
               busy, done, err, num, den);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_gcd_ignored();
    gcd = 16'd5; gcd_done = 1'b1;
    tick();
    gcd_done = 1'b0; gcd = '0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_gcd got busy=%b done=%b want 0 0", busy, done);
    end
    tick();
  endtask

  task automatic test_basic();
    run_case(16'd9, 16'd3);
    run_case(16'd5, 16'd2);
    run_case(16'd24, 16'd36);
  endtask

  task automatic test_boundaries();
    run_case(16'hFFFF, 16'h00FF);
    run_case(16'd0, 16'd7);
    run_case(16'd0, 16'd0);
    run_case(16'd7, 16'd7);
    run_case(16'hFFFF, 16'hFFFF);
    run_case(16'hFFFE, 16'd1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_case(16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535)));
  endtask

  task automatic test_abort();
    int seen0;
    a = 16'd12; b = 16'd18; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    gcd = gcd_model(16'd12, 16'd18); gcd_done = 1'b1;
    tick();
    gcd_done = 1'b0; gcd = '0;
    repeat (5) tick();
    a = 16'd100; b = 16'd50; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    repeat (10) tick();
    n_cmp++;
    if (num !== 16'd12 / gcd_model(16'd12, 16'd18) || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_num got num=%0d busy=%b want 2 1", num, busy);
    end
    repeat (4) tick();
    seen0 = done_seen;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({busy, done, err, num, den} !== 35'd0) begin
      n_bad++;
      $display("FAIL abort_reset got busy=%b done=%b err=%b num=%0d den=%0d want all 0",
               busy, done, err, num, den);
    end
    #3 rst_n = 1'b1;
    repeat (40) tick();
    n_cmp++;
    if (done_seen != seen0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_done got pulses=%0d busy=%b want 0 0", done_seen - seen0, busy);
    end
    run_case(16'd12, 16'd18);
  endtask

  initial begin
    test_reset();
    test_idle_gcd_ignored();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
